decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Parametrised RV32I(+M) instruction decode stage sitting between fetch and issue, with a valid/ready handshake on both sides and a flush input.
Splits each 32-bit instruction into register indices, a sign-extended immediate, an opcodes_t operation, operand-use flags and an illegal flag.
Register depth and M-extension support are configurable.
Output buffering is elastic: downstream stalls never drop or duplicate instructions.

Parameters:
XLEN, 32, datapath and pc width (core_config_pkg value)
IF_LEN, 32, instruction width
REG_ADDR_W, 5, register index width
PIPE_DEPTH, 2, number of register stages from input to output; legal range 1..3
M_EXT, 1, 1 = MUL/DIV/REM decoded as legal; 0 = funct7=0000001 R-type flagged illegal

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
i_valid  in  1  fetch offers an instruction
i_ready  out  1  stage can accept this cycle
i_instr  in  IF_LEN  instruction word
i_pc  in  XLEN  instruction address
flush  in  1  discard all in-flight instructions
o_valid  out  1  decoded instruction available
o_ready  in  1  issue accepts this cycle
o_pc  out  XLEN  pc travelling with the instruction
opcode  out  opcodes_t  decoded operation
rs1, rs2, rd  out  REG_ADDR_W each  register indices
imm  out  XLEN  immediate
uses_rs1, uses_rs2, writes_rd  out  1 each  operand-use flags
illegal  out  1  instruction not recognised

Behaviour:
- Reset: o_valid=0, all stage valid bits 0, opcode=i_NOP, every other output 0. i_ready=1 from the first cycle after reset release.
- Decode is combinational on i_instr and captured into stage 0. Stages 1..PIPE_DEPTH-1 are plain register copies. Outputs are driven directly from the last stage.
- Each stage k loads when it is empty or stage k+1 loads/drains this cycle (bubble-collapsing). Last stage drains on o_valid & o_ready.
- i_ready = stage 0 can load. An instruction is accepted on i_valid & i_ready.
- Latency: accept at cycle N gives o_valid at cycle N+PIPE_DEPTH when unstalled. Throughput is 1 per cycle with o_ready held high.
- Outputs are stable while o_valid & !o_ready.
- Decode per format:
  - R: rd, rs1, rs2 taken from the instruction.
  - I: rd, rs1; imm = sext(instr[31:20]).
  - S: rs1, rs2; imm = sext({instr[31:25], instr[11:7]}).
  - B: rs1, rs2; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: rd; imm = {instr[31:12], 12'h0}.
  - J (JAL): rd; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - SRAI vs SRLI selected by instr[30].
  - SYSTEM funct3=000: ECALL (000), EBREAK (001) or MRET (302) from instr[31:20]; rs1, rd, imm forced 0. CSR funct3 values map to the CSRR* ops.
- writes_rd = format writes rd AND rd != 0.
- uses_rs1 / uses_rs2 are set per format. CSR*I ops set uses_rs1 = 0 (the rs1 field is a uimm).
- Illegal: set for an unknown opcode field, an unmapped funct3/funct7, instr == 0, or instr[1:0] != 2'b11. When illegal: opcode=i_NOP, all indices, imm and use flags 0; o_pc still valid. Illegal instructions flow through the pipe and handshake normally.
- flush: all valid bits cleared at the next edge, and i_valid is ignored that cycle (i_ready may read 1 but nothing is captured). o_valid=0 the cycle after flush.
- flush together with an o_valid & o_ready handshake: that output counts as consumed.
- rst_n asserted mid-operation: immediate return to reset values, regardless of clk.

Optional Feature:
Macro DECODE_PERF_CNT_EN.
- Defined: adds outputs cnt_decoded (32) and cnt_illegal (32). cnt_decoded increments on each output handshake; cnt_illegal also increments when illegal=1 on that handshake. Both wrap modulo 2^32, reset to 0, and are unaffected by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- core_config_pkg gains:
  - PIPE_DEPTH_MAX = 3
  - a dec_out_t struct {opcode, rs1, rs2, rd, imm, uses_rs1, uses_rs2, writes_rd, illegal}
  - RV opcode-field localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM)
- opcodes_t and field MSB/LSB constants are reused unchanged.
- One sub-module: rv32_decode_comb, purely combinational, taking instr and M_EXT and returning dec_out_t. decode_stage holds the stage registers, handshake and flush.

Test Plan:
- PIPE_DEPTH=2, o_ready=1: i_instr=0xFFF10093 (addi x1,x2,-1) at cycle 0 -> o_valid at cycle 2; opcode=i_ADDI, rd=1, rs1=2, imm=0xFFFFFFFF, writes_rd=1, uses_rs2=0.
- 0x123452B7 -> i_LUI, rd=5, imm=0x12345000. 0x00000073 -> i_ECALL, rs1=rd=imm=0.
- M_EXT=0: 0x022081B3 -> illegal=1, opcode=i_NOP. M_EXT=1: same word -> i_MUL, rd=3, rs1=1, rs2=2. 0x00000000 -> illegal=1.
- PIPE_DEPTH=2, 5 back-to-back instructions, o_ready low for cycles 3..6 -> i_ready drops once both stages are full; all 5 emerge in order with no duplicates; outputs stable while stalled.
- Two instructions in flight, flush pulse -> o_valid=0 next cycle; next accepted instruction appears PIPE_DEPTH cycles later.
- DECODE_PERF_CNT_EN defined: 10 handshakes including 3 illegal -> cnt_decoded=10, cnt_illegal=3; async reset mid-stream -> both 0.

Source files
------------

// File: rtl/core_config_pkg.sv
// core_config_pkg: shared core configuration for the RV32I(+M) front end.
// Holds datapath widths, the instruction-field bit positions, the RV opcode
// field values, the opcodes_t operation enum, the dec_out_t decode bundle and
// a helper returning the reset value of that bundle.
package core_config_pkg;

  localparam int CFG_XLEN       = 32;
  localparam int CFG_IF_LEN     = 32;
  localparam int CFG_REG_ADDR_W = 5;
  localparam int PIPE_DEPTH_MAX = 3;

  // Instruction field positions
  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_MSB    = 19;
  localparam int RS1_LSB    = 15;
  localparam int RS2_MSB    = 24;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_MSB = 31;
  localparam int FUNCT7_LSB = 25;

  // RV opcode field values
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // i_NOP is encoding 0 so an all-zero bundle reads as a NOP
  typedef enum logic [5:0] {
    i_NOP, i_LUI, i_AUIPC, i_JAL, i_JALR,
    i_BEQ, i_BNE, i_BLT, i_BGE, i_BLTU, i_BGEU,
    i_LB, i_LH, i_LW, i_LBU, i_LHU, i_SB, i_SH, i_SW,
    i_ADDI, i_SLTI, i_SLTIU, i_XORI, i_ORI, i_ANDI, i_SLLI, i_SRLI, i_SRAI,
    i_ADD, i_SUB, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_SRA, i_OR, i_AND,
    i_MUL, i_MULH, i_MULHSU, i_MULHU, i_DIV, i_DIVU, i_REM, i_REMU,
    i_FENCE, i_ECALL, i_EBREAK, i_MRET,
    i_CSRRW, i_CSRRS, i_CSRRC, i_CSRRWI, i_CSRRSI, i_CSRRCI
  } opcodes_t;

  typedef struct packed {
    opcodes_t                  opcode;
    logic [CFG_REG_ADDR_W-1:0] rs1;
    logic [CFG_REG_ADDR_W-1:0] rs2;
    logic [CFG_REG_ADDR_W-1:0] rd;
    logic [CFG_XLEN-1:0]       imm;
    logic                      uses_rs1;
    logic                      uses_rs2;
    logic                      writes_rd;
    logic                      illegal;
  } dec_out_t;

  function automatic dec_out_t dec_out_rst();
    dec_out_t v;
    v        = '0;
    v.opcode = i_NOP;
    return v;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and issue-side handshake bundle of the decode
// stage. master = surrounding pipeline (fetch drives the instruction, issue
// drives o_ready); slave = decode_stage.
interface decode_stage_if #(
  parameter int XLEN       = core_config_pkg::CFG_XLEN,
  parameter int IF_LEN     = core_config_pkg::CFG_IF_LEN,
  parameter int REG_ADDR_W = core_config_pkg::CFG_REG_ADDR_W
) ();
  import core_config_pkg::*;

  logic                  i_valid;
  logic                  i_ready;
  logic [IF_LEN-1:0]     i_instr;
  logic [XLEN-1:0]       i_pc;
  logic                  flush;
  logic                  o_valid;
  logic                  o_ready;
  logic [XLEN-1:0]       o_pc;
  opcodes_t              opcode;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       imm;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  writes_rd;
  logic                  illegal;

  modport master (
    output i_valid, i_instr, i_pc, flush, o_ready,
    input  i_ready, o_valid, o_pc, opcode, rs1, rs2, rd, imm,
           uses_rs1, uses_rs2, writes_rd, illegal
  );

  modport slave (
    input  i_valid, i_instr, i_pc, flush, o_ready,
    output i_ready, o_valid, o_pc, opcode, rs1, rs2, rd, imm,
           uses_rs1, uses_rs2, writes_rd, illegal
  );
endinterface

// File: rtl/rv32_decode_comb.sv
// rv32_decode_comb: purely combinational RV32I(+M) decoder.
// Ports: instr (in, 32-bit word) -> dec (out, dec_out_t bundle).
// Parameter M_EXT: 1 decodes MUL/DIV/REM, 0 reports them illegal.
module rv32_decode_comb
  import core_config_pkg::*;
#(
  parameter bit M_EXT = 1'b1
) (
  input  logic [CFG_IF_LEN-1:0] instr,
  output dec_out_t              dec
);

  logic [6:0]          opf_s;
  logic [2:0]          f3_s;
  logic [6:0]          f7_s;
  logic [CFG_XLEN-1:0] i_imm_s;
  opcodes_t            op_s;
  logic [CFG_XLEN-1:0] imm_s;
  logic                has_rd_s, has_rs1_s, has_rs2_s, uimm_s, bad_s;

  assign opf_s   = instr[OPCODE_MSB:OPCODE_LSB];
  assign f3_s    = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign f7_s    = instr[FUNCT7_MSB:FUNCT7_LSB];
  assign i_imm_s = {{20{instr[31]}}, instr[31:20]};

  // Operation, immediate and operand usage per opcode field
  always_comb begin
    op_s      = i_NOP;
    imm_s     = '0;
    has_rd_s  = 1'b0;
    has_rs1_s = 1'b0;
    has_rs2_s = 1'b0;
    uimm_s    = 1'b0;
    bad_s     = 1'b0;
    case (opf_s)
      OP_LUI, OP_AUIPC: begin
        op_s     = (opf_s == OP_LUI) ? i_LUI : i_AUIPC;
        has_rd_s = 1'b1;
        imm_s    = {instr[31:12], 12'h000};
      end
      OP_JAL: begin
        op_s     = i_JAL;
        has_rd_s = 1'b1;
        imm_s    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        op_s      = i_JALR;
        has_rd_s  = 1'b1;
        has_rs1_s = 1'b1;
        imm_s     = i_imm_s;
        bad_s     = (f3_s != 3'b000);
      end
      OP_BRANCH: begin
        has_rs1_s = 1'b1;
        has_rs2_s = 1'b1;
        imm_s     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3_s)
          3'b000:  op_s = i_BEQ;
          3'b001:  op_s = i_BNE;
          3'b100:  op_s = i_BLT;
          3'b101:  op_s = i_BGE;
          3'b110:  op_s = i_BLTU;
          3'b111:  op_s = i_BGEU;
          default: bad_s = 1'b1;
        endcase
      end
      OP_LOAD: begin
        has_rd_s  = 1'b1;
        has_rs1_s = 1'b1;
        imm_s     = i_imm_s;
        case (f3_s)
          3'b000:  op_s = i_LB;
          3'b001:  op_s = i_LH;
          3'b010:  op_s = i_LW;
          3'b100:  op_s = i_LBU;
          3'b101:  op_s = i_LHU;
          default: bad_s = 1'b1;
        endcase
      end
      OP_STORE: begin
        has_rs1_s = 1'b1;
        has_rs2_s = 1'b1;
        imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        case (f3_s)
          3'b000:  op_s = i_SB;
          3'b001:  op_s = i_SH;
          3'b010:  op_s = i_SW;
          default: bad_s = 1'b1;
        endcase
      end
      OP_IMM: begin
        has_rd_s  = 1'b1;
        has_rs1_s = 1'b1;
        imm_s     = i_imm_s;
        case (f3_s)
          3'b000:  op_s = i_ADDI;
          3'b010:  op_s = i_SLTI;
          3'b011:  op_s = i_SLTIU;
          3'b100:  op_s = i_XORI;
          3'b110:  op_s = i_ORI;
          3'b111:  op_s = i_ANDI;
          3'b001: begin
            op_s  = i_SLLI;
            bad_s = (f7_s != 7'b0000000);
          end
          3'b101: begin
            // instr[30] picks arithmetic vs logical; other funct7 bits must be 0
            op_s  = instr[30] ? i_SRAI : i_SRLI;
            bad_s = ({f7_s[6], f7_s[4:0]} != 6'b000000);
          end
          default: bad_s = 1'b1;
        endcase
      end
      OP_REG: begin
        has_rd_s  = 1'b1;
        has_rs1_s = 1'b1;
        has_rs2_s = 1'b1;
        case ({f7_s, f3_s})
          10'b0000000_000: op_s = i_ADD;
          10'b0100000_000: op_s = i_SUB;
          10'b0000000_001: op_s = i_SLL;
          10'b0000000_010: op_s = i_SLT;
          10'b0000000_011: op_s = i_SLTU;
          10'b0000000_100: op_s = i_XOR;
          10'b0000000_101: op_s = i_SRL;
          10'b0100000_101: op_s = i_SRA;
          10'b0000000_110: op_s = i_OR;
          10'b0000000_111: op_s = i_AND;
          10'b0000001_000: op_s = i_MUL;
          10'b0000001_001: op_s = i_MULH;
          10'b0000001_010: op_s = i_MULHSU;
          10'b0000001_011: op_s = i_MULHU;
          10'b0000001_100: op_s = i_DIV;
          10'b0000001_101: op_s = i_DIVU;
          10'b0000001_110: op_s = i_REM;
          10'b0000001_111: op_s = i_REMU;
          default:         bad_s = 1'b1;
        endcase
        if (f7_s == 7'b0000001) begin
          bad_s = bad_s | ~M_EXT;
        end else begin
          bad_s = bad_s;
        end
      end
      OP_FENCE: begin
        op_s  = i_FENCE;
        bad_s = (f3_s != 3'b000);
      end
      OP_SYSTEM: begin
        case (f3_s)
          3'b000: begin
            // Privileged ops carry no operands: rd, rs1 and imm stay 0
            case (instr[31:20])
              12'h000: op_s = i_ECALL;
              12'h001: op_s = i_EBREAK;
              12'h302: op_s = i_MRET;
              default: bad_s = 1'b1;
            endcase
          end
          3'b001, 3'b010, 3'b011: begin
            op_s      = (f3_s == 3'b001) ? i_CSRRW : (f3_s == 3'b010) ? i_CSRRS : i_CSRRC;
            has_rd_s  = 1'b1;
            has_rs1_s = 1'b1;
            imm_s     = i_imm_s;
          end
          3'b101, 3'b110, 3'b111: begin
            // rs1 field is a 5-bit uimm: passed through but not a register read
            op_s     = (f3_s == 3'b101) ? i_CSRRWI : (f3_s == 3'b110) ? i_CSRRSI : i_CSRRCI;
            has_rd_s = 1'b1;
            uimm_s   = 1'b1;
            imm_s    = i_imm_s;
          end
          default: bad_s = 1'b1;
        endcase
      end
      default: bad_s = 1'b1;
    endcase
    bad_s = bad_s | (instr == 32'h0000_0000) | (instr[1:0] != 2'b11);
  end

  // Assemble the bundle; illegal words collapse to a zeroed NOP
  always_comb begin
    dec = dec_out_rst();
    if (bad_s) begin
      dec.illegal = 1'b1;
    end else begin
      dec.opcode    = op_s;
      dec.rd        = has_rd_s ? instr[RD_MSB:RD_LSB] : 5'd0;
      dec.rs1       = (has_rs1_s | uimm_s) ? instr[RS1_MSB:RS1_LSB] : 5'd0;
      dec.rs2       = has_rs2_s ? instr[RS2_MSB:RS2_LSB] : 5'd0;
      dec.imm       = imm_s;
      dec.uses_rs1  = has_rs1_s;
      dec.uses_rs2  = has_rs2_s;
      dec.writes_rd = has_rd_s & (instr[RD_MSB:RD_LSB] != 5'd0);
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: elastic RV32I(+M) decode pipeline between fetch and issue.
// Ports: clk, rst_n (async active-low); bus (decode_stage_if.slave) carrying
// i_valid/i_ready/i_instr/i_pc/flush and o_valid/o_ready/o_pc plus decoded
// opcode, rs1, rs2, rd, imm, uses_rs1, uses_rs2, writes_rd, illegal.
// Optional macro DECODE_PERF_CNT_EN adds cnt_decoded / cnt_illegal outputs
// (32-bit, wrapping, untouched by flush).
// PIPE_DEPTH register stages (1..PIPE_DEPTH_MAX); stage 0 captures the
// combinational decode, later stages copy, outputs come from the last stage.
module decode_stage
  import core_config_pkg::*;
#(
  parameter int XLEN       = CFG_XLEN,
  parameter int IF_LEN     = CFG_IF_LEN,
  parameter int REG_ADDR_W = CFG_REG_ADDR_W,
  parameter int PIPE_DEPTH = 2,
  parameter bit M_EXT      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  decode_stage_if.slave bus
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0] cnt_decoded,
  output logic [31:0] cnt_illegal
`endif
);

  localparam int LAST = PIPE_DEPTH - 1;

  logic [IF_LEN-1:0]     instr_s;
  dec_out_t              dec_s;
  logic [PIPE_DEPTH-1:0] valid_r;
  logic [PIPE_DEPTH-1:0] load_s;
  logic                  all_full_s;
  logic                  drain_s;
  dec_out_t              dec_r [PIPE_DEPTH];
  logic [XLEN-1:0]       pc_r  [PIPE_DEPTH];

  assign instr_s = bus.i_instr;

  rv32_decode_comb #(.M_EXT(M_EXT)) u_dec (
    .instr (instr_s),
    .dec   (dec_s)
  );

  // Stage k may load when any stage from k to the output is empty or the
  // head drains: bubbles collapse without waiting for downstream
  always_comb begin
    load_s     = '0;
    all_full_s = 1'b1;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      all_full_s = 1'b1;
      for (int j = k; j < PIPE_DEPTH; j++) begin
        all_full_s = all_full_s & valid_r[j];
      end
      load_s[k] = bus.o_ready | ~all_full_s;
    end
  end

  assign drain_s = valid_r[LAST] & bus.o_ready;

  // Stage valid bits and payload; flush empties every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        dec_r[k] <= dec_out_rst();
        pc_r[k]  <= '0;
      end
    end else begin
      if (load_s[0]) begin
        dec_r[0] <= dec_s;
        pc_r[0]  <= bus.i_pc;
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (load_s[k]) begin
          dec_r[k] <= dec_r[k-1];
          pc_r[k]  <= pc_r[k-1];
        end
      end
      if (bus.flush) begin
        valid_r <= '0;
      end else begin
        if (load_s[0]) valid_r[0] <= bus.i_valid;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
          if (load_s[k]) valid_r[k] <= valid_r[k-1];
        end
      end
    end
  end

  assign bus.i_ready   = load_s[0];
  assign bus.o_valid   = valid_r[LAST];
  assign bus.o_pc      = pc_r[LAST];
  assign bus.opcode    = dec_r[LAST].opcode;
  assign bus.rs1       = REG_ADDR_W'(dec_r[LAST].rs1);
  assign bus.rs2       = REG_ADDR_W'(dec_r[LAST].rs2);
  assign bus.rd        = REG_ADDR_W'(dec_r[LAST].rd);
  assign bus.imm       = XLEN'(dec_r[LAST].imm);
  assign bus.uses_rs1  = dec_r[LAST].uses_rs1;
  assign bus.uses_rs2  = dec_r[LAST].uses_rs2;
  assign bus.writes_rd = dec_r[LAST].writes_rd;
  assign bus.illegal   = dec_r[LAST].illegal;

`ifdef DECODE_PERF_CNT_EN
  // Handshake counters; a handshake in a flush cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_decoded <= 32'd0;
      cnt_illegal <= 32'd0;
    end else if (drain_s) begin
      cnt_decoded <= cnt_decoded + 32'd1;
      if (dec_r[LAST].illegal) cnt_illegal <= cnt_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: PIPE_DEPTH=2/M_EXT=1 main instance plus a
// PIPE_DEPTH=1/M_EXT=0 instance for the M-extension-disabled case.
module tb_decode_stage;
  import core_config_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage_if bus_m0 ();

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] cnt_decoded, cnt_illegal, cnt_decoded_m0, cnt_illegal_m0;
`endif

  decode_stage #(.PIPE_DEPTH(2), .M_EXT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef DECODE_PERF_CNT_EN
    , .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
`endif
  );

  decode_stage #(.PIPE_DEPTH(1), .M_EXT(1'b0)) u_dut_m0 (
    .clk(clk), .rst_n(rst_n), .bus(bus_m0)
`ifdef DECODE_PERF_CNT_EN
    , .cnt_decoded(cnt_decoded_m0), .cnt_illegal(cnt_illegal_m0)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    opcodes_t    op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        u1, u2, wr, ill;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_ill, sent, got;
    logic stalled_prev, saw_block;
    logic [31:0] held_pc, held_imm;

    vecs[0]  = '{32'hFFF10093, i_ADDI,   5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h123452B7, i_LUI,    5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h00000073, i_ECALL,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h022081B3, i_MUL,    5'd3, 5'd1, 5'd2, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{32'h00000000, i_NOP,    5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h00512423, i_SW,     5'd0, 5'd2, 5'd5, 32'h00000008, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'hFE208EE3, i_BEQ,    5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h008000EF, i_JAL,    5'd1, 5'd0, 5'd0, 32'h00000008, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'h40525193, i_SRAI,   5'd3, 5'd4, 5'd0, 32'h00000405, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h3003D2F3, i_CSRRWI, 5'd5, 5'd7, 5'd0, 32'h00000300, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'hFFF10090, i_NOP,    5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h00000013, i_ADDI,   5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h0000007F, i_NOP,    5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};

    bus.i_valid = 1'b0; bus.i_instr = 32'h0; bus.i_pc = 32'h0; bus.flush = 1'b0; bus.o_ready = 1'b1;
    bus_m0.i_valid = 1'b0; bus_m0.i_instr = 32'h0; bus_m0.i_pc = 32'h0;
    bus_m0.flush = 1'b0; bus_m0.o_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", bus.o_valid, 32'd0);
    check("rst_opcode", bus.opcode, i_NOP);
    check("rst_imm", bus.imm, 32'd0);
    check("rst_o_pc", bus.o_pc, 32'd0);
    check("rst_rd", bus.rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_i_ready", bus.i_ready, 32'd1);

    // directed decode vectors, one at a time, latency measured
    n_ill = 0;
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].ill) n_ill++;
      bus.i_valid = 1'b1;
      bus.i_instr = vecs[i].instr;
      bus.i_pc    = 32'h1000 + 32'(4 * i);
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      lat = 1;
      while (!bus.o_valid && lat < 10) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      check($sformatf("v%0d.latency", i), lat, 32'd2);
      check($sformatf("v%0d.o_pc", i), bus.o_pc, 32'h1000 + 32'(4 * i));
      check($sformatf("v%0d.opcode", i), bus.opcode, vecs[i].op);
      check($sformatf("v%0d.rd", i), bus.rd, vecs[i].rd);
      check($sformatf("v%0d.rs1", i), bus.rs1, vecs[i].rs1);
      check($sformatf("v%0d.rs2", i), bus.rs2, vecs[i].rs2);
      check($sformatf("v%0d.imm", i), bus.imm, vecs[i].imm);
      check($sformatf("v%0d.uses_rs1", i), bus.uses_rs1, vecs[i].u1);
      check($sformatf("v%0d.uses_rs2", i), bus.uses_rs2, vecs[i].u2);
      check($sformatf("v%0d.writes_rd", i), bus.writes_rd, vecs[i].wr);
      check($sformatf("v%0d.illegal", i), bus.illegal, vecs[i].ill);
    end
    @(posedge clk);
    @(negedge clk);
    check("drain_o_valid", bus.o_valid, 32'd0);
`ifdef DECODE_PERF_CNT_EN
    check("perf_cnt_decoded", cnt_decoded, NVEC);
    check("perf_cnt_illegal", cnt_illegal, n_ill);
`endif

    // M extension disabled, single stage: MUL is illegal, latency 1
    bus_m0.i_valid = 1'b1;
    bus_m0.i_instr = 32'h022081B3;
    bus_m0.i_pc    = 32'h2000;
    @(posedge clk);
    @(negedge clk);
    bus_m0.i_valid = 1'b0;
    check("m0_o_valid", bus_m0.o_valid, 32'd1);
    check("m0_illegal", bus_m0.illegal, 32'd1);
    check("m0_opcode", bus_m0.opcode, i_NOP);
    check("m0_rd", bus_m0.rd, 32'd0);
    check("m0_rs1", bus_m0.rs1, 32'd0);
    check("m0_o_pc", bus_m0.o_pc, 32'h2000);

    // back-to-back with o_ready low for cycles 3..6
    sent = 0; got = 0; stalled_prev = 1'b0; saw_block = 1'b0;
    held_pc = 32'h0; held_imm = 32'h0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (stalled_prev) begin
        check("stall_hold_valid", bus.o_valid, 32'd1);
        check("stall_hold_pc", bus.o_pc, held_pc);
        check("stall_hold_imm", bus.imm, held_imm);
      end
      bus.o_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 5) begin
        bus.i_valid = 1'b1;
        bus.i_instr = (32'(sent + 1) << 20) | (32'(sent + 1) << 7) | 32'h13;
        bus.i_pc    = 32'h3000 + 32'(4 * sent);
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (bus.o_valid && bus.o_ready) begin
        check($sformatf("stall_out%0d_pc", got), bus.o_pc, 32'h3000 + 32'(4 * got));
        check($sformatf("stall_out%0d_imm", got), bus.imm, 32'(got + 1));
        got++;
      end
      if (bus.o_valid && !bus.o_ready) begin
        stalled_prev = 1'b1;
        held_pc  = bus.o_pc;
        held_imm = bus.imm;
      end else begin
        stalled_prev = 1'b0;
      end
      if (bus.i_valid && !bus.i_ready) saw_block = 1'b1;
      if (bus.i_valid && bus.i_ready) sent++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    check("stall_out_count", got, 32'd5);
    check("stall_i_ready_dropped", saw_block, 32'd1);

    // flush with two in flight; concurrent i_valid must be ignored
    for (int k = 0; k < 2; k++) begin
      bus.i_valid = 1'b1;
      bus.i_instr = 32'h00100093;
      bus.i_pc    = 32'h4000 + 32'(4 * k);
      @(posedge clk);
      @(negedge clk);
    end
    bus.flush   = 1'b1;
    bus.i_instr = 32'h00200113;
    bus.i_pc    = 32'h4008;
    #1;
    check("flush_pre_o_valid", bus.o_valid, 32'd1);
    check("flush_pre_i_ready", bus.i_ready, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("flush_idle%0d_o_valid", k), bus.o_valid, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_valid = 1'b1;
    bus.i_instr = 32'h00300193;
    bus.i_pc    = 32'h400C;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("post_flush_lat1_o_valid", bus.o_valid, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("post_flush_o_valid", bus.o_valid, 32'd1);
    check("post_flush_o_pc", bus.o_pc, 32'h400C);
    check("post_flush_rd", bus.rd, 32'd3);

    // asynchronous reset mid-stream
    bus.i_valid = 1'b1;
    bus.i_instr = 32'h00500293;
    bus.i_pc    = 32'h5000;
    @(posedge clk);
    @(negedge clk);
    bus.o_ready = 1'b0;
    bus.i_pc    = 32'h5004;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("arst_pre_o_valid", bus.o_valid, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", bus.o_valid, 32'd0);
    check("arst_opcode", bus.opcode, i_NOP);
    check("arst_o_pc", bus.o_pc, 32'd0);
    check("arst_imm", bus.imm, 32'd0);
    check("arst_writes_rd", bus.writes_rd, 32'd0);
`ifdef DECODE_PERF_CNT_EN
    check("arst_cnt_decoded", cnt_decoded, 32'd0);
    check("arst_cnt_illegal", cnt_illegal, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bus.o_ready = 1'b1;
    @(negedge clk);
    check("arst_release_i_ready", bus.i_ready, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
